read_from_fifo: RTL
===================

Name: read_from_fifo

Overview:
- Read-side counterpart of the AES host write path.
- Buffers 128-bit ciphertext blocks from the AES core in a small block FIFO.
- Returns each block to the host over the register read channel (arvalid_q/araddr_q → rvalid/rdata/rresp/rready) as byte-indexed 32-bit words, in the same format the host uses to write key and plaintext bytes.
- Sits between the AES core output and the CL register read mux.

Parameters:
- DEPTH, 2: number of 128-bit ciphertext blocks buffered (power of 2, ≥2).
- DATA_ADDR, 32'h0000_0510: read address that pops ciphertext bytes.
- STATUS_ADDR, 32'h0000_0514: read address returning FIFO status, no side effects.

Ports:
- clk_main_a0  in  1  main clock.
- rst_main_n_sync  in  1  reset.
- ct_valid  in  1  AES core ciphertext strobe.
- ct_data  in  128  ciphertext; byte 0 = ct_data[127:120].
- ct_ready  out  1  FIFO can accept a block.
- arvalid_q  in  1  read request valid.
- araddr_q  in  32  read address.
- rready  in  1  host accepts read data.
- rvalid  out  1  read data valid.
- rdata  out  32  read data.
- rresp  out  2  response: 2'b00 OKAY, 2'b10 SLVERR.

Interface: one clock; reset is asynchronous and active-low. Clock is clk_main_a0, reset is rst_main_n_sync; all state is on clk_main_a0 rising edge.

Behaviour:
- Reset (asynchronous, any time including mid-transaction) forces:
  - rvalid=0, rdata=0, rresp=0.
  - FIFO empty, write/read pointers 0, byte pointer bp=0, FSM in IDLE.
  - ct_ready=1 after reset.
- Push:
  - ct_ready = (count < DEPTH), combinational from registered count.
  - Block written when ct_valid && ct_ready.
  - ct_valid while full is dropped; count unchanged.
- Read FSM, two states:
  - IDLE: on arvalid_q at a rising edge, decode araddr_q, register rdata/rresp, set rvalid=1, go to RESP. One-cycle latency from request edge to rvalid.
  - RESP: hold rvalid, rdata and rresp stable until rready. On rvalid && rready, apply side effects, drop rvalid, return to IDLE. arvalid_q is ignored in RESP, so at most one read is outstanding and back-to-back reads take ≥2 cycles each.
- DATA_ADDR read, FIFO non-empty:
  - rdata = {tag[3:0], 20'h0, byte[7:0]}.
  - byte = head block byte bp.
  - tag = (16 − bp) mod 16, i.e. 0, F, E, …, 1.
  - rresp=OKAY.
  - On handshake: bp increments. At bp=15, bp wraps to 0 and the head block pops (count−1).
- DATA_ADDR read, FIFO empty: rdata=0, rresp=SLVERR, no state change.
- STATUS_ADDR read:
  - rdata[7:0] = count.
  - rdata[8] = empty, rdata[9] = full.
  - rdata[19:16] = bp.
  - Other bits 0; rresp=OKAY; no side effects.
- Any other address: rdata=0, rresp=SLVERR, no side effects.
- Simultaneous push and final-byte pop in the same cycle: both take effect; count unchanged.
  - If full, the push is refused that cycle because ct_ready comes from the pre-pop count.
- Pointers wrap modulo DEPTH.
- Status reads mid-block report the current bp.

Optional Feature:
- Macro READ_FIFO_WORD_MODE_EN.
- Defined:
  - DATA_ADDR reads return whole 32-bit words, 4 per block, most-significant word first (ct_data[127:96] first).
  - bp counts 0..3; the block pops after word 3.
  - No tag field.
  - STATUS rdata[19:16] reports the word index.
- Undefined: byte mode as described above.

Test Plan:
- Reset mid-RESP: assert reset with rvalid=1 → rvalid=0, rdata=0, ct_ready=1 immediately (asynchronous). STATUS read afterwards → 32'h0000_0100.
- Single-block readback:
  - Push 128'h69c4e0d86a7b0430d8cdb78070b4c55a, then 16 DATA reads with rready=1.
  - Required rdata sequence: 0x0000_0069, 0xF000_00C4, 0xE000_00E0, … 0x1000_005A; all OKAY.
  - Then STATUS → 0x0000_0100.
- rready backpressure: hold rready=0 for 5 cycles after rvalid → rdata stable; second arvalid_q ignored; bp advances exactly once.
- Full FIFO: push two distinct blocks → ct_ready=0; third push is dropped.
  - Read 16 bytes: first block returned; ct_ready rises the cycle after the pop.
  - Next 16 bytes: second block returned.
- Error paths: DATA read when empty → rdata=0, rresp=2'b10. Read 0x0000_0520 → SLVERR, state unchanged.
- Simultaneous event: with DEPTH full, final-byte handshake plus ct_valid in the same cycle → push refused, count goes 2→1.
  - With count=1, the same event keeps count=1 and the new block is read next.

Source files
------------

// File: rtl/read_from_fifo_if.sv
// Bus bundle for read_from_fifo: AES ciphertext push side plus the host register read channel.
interface read_from_fifo_if;
   logic         ct_valid;
   logic [127:0] ct_data;
   logic         ct_ready;
   logic         arvalid_q;
   logic [31:0]  araddr_q;
   logic         rready;
   logic         rvalid;
   logic [31:0]  rdata;
   logic [1:0]   rresp;

   modport slave (
      input  ct_valid, ct_data, arvalid_q, araddr_q, rready,
      output ct_ready, rvalid, rdata, rresp
   );

   modport master (
      output ct_valid, ct_data, arvalid_q, araddr_q, rready,
      input  ct_ready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/read_from_fifo.sv
// Ciphertext block FIFO drained byte-by-byte (or word-by-word when READ_FIFO_WORD_MODE_EN
// is defined) through a single-outstanding register read channel.
module read_from_fifo #(
   parameter int unsigned DEPTH       = 2,
   parameter logic [31:0] DATA_ADDR   = 32'h0000_0510,
   parameter logic [31:0] STATUS_ADDR = 32'h0000_0514
) (
   input logic              clk_main_a0,
   input logic              rst_main_n_sync,
   read_from_fifo_if.slave  bus
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
`ifdef READ_FIFO_WORD_MODE_EN
   localparam logic [3:0]  BP_LAST = 4'd3;
`else
   localparam logic [3:0]  BP_LAST = 4'd15;
`endif

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [127:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [3:0]       r_bp;
   logic [0:0]       r_state;
   logic             r_rvalid;
   logic [31:0]      r_rdata;
   logic [1:0]       r_rresp;
   logic             r_data_hit;

   logic             w_empty;
   logic             w_full;
   logic             w_ct_ready;
   logic             w_push;
   logic             w_adv;
   logic             w_pop;
   logic [127:0]     w_head;
   logic [31:0]      w_data_word;
   logic [31:0]      w_status_word;
   logic [0:0]       w_state_nxt;
   logic             w_rvalid_nxt;
   logic [31:0]      w_rdata_nxt;
   logic [1:0]       w_rresp_nxt;
   logic             w_data_hit_nxt;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_ct_ready = (r_count < CNT_W'(DEPTH));
   assign w_push     = bus.ct_valid && w_ct_ready;
   assign w_pop      = w_adv && (r_bp == BP_LAST);
   assign w_head     = r_mem[r_rd_ptr];

   assign bus.ct_ready = w_ct_ready;
   assign bus.rvalid   = r_rvalid;
   assign bus.rdata    = r_rdata;
   assign bus.rresp    = r_rresp;

`ifdef READ_FIFO_WORD_MODE_EN
   // Most-significant word of the head block is word 0.
   logic [31:0] w_words [4];
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_words[i] = w_head[127 - 32*i -: 32];
      end
      w_data_word = w_words[r_bp[1:0]];
   end
`else
   // Byte 0 is the top byte; tag counts down 0, F, E, ... 1 as the byte pointer advances.
   logic [7:0] w_bytes [16];
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         w_bytes[i] = w_head[127 - 8*i -: 8];
      end
      w_data_word = {4'(5'd16 - {1'b0, r_bp}), 20'h0_0000, w_bytes[r_bp]};
   end
`endif

   assign w_status_word = {12'h000, r_bp, 6'h00, w_full, w_empty, 8'(r_count)};

   // Read FSM: state register
   always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
      if (!rst_main_n_sync) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Read FSM: decode on request, release and flag side effects on handshake
   always_comb begin
      w_state_nxt    = r_state;
      w_rvalid_nxt   = r_rvalid;
      w_rdata_nxt    = r_rdata;
      w_rresp_nxt    = r_rresp;
      w_data_hit_nxt = r_data_hit;
      w_adv          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.arvalid_q) begin
               w_state_nxt  = ST_RESP;
               w_rvalid_nxt = 1'b1;
               if (bus.araddr_q == DATA_ADDR && !w_empty) begin
                  w_rdata_nxt    = w_data_word;
                  w_rresp_nxt    = RESP_OKAY;
                  w_data_hit_nxt = 1'b1;
               end else if (bus.araddr_q == STATUS_ADDR) begin
                  w_rdata_nxt    = w_status_word;
                  w_rresp_nxt    = RESP_OKAY;
                  w_data_hit_nxt = 1'b0;
               end else begin
                  w_rdata_nxt    = 32'h0000_0000;
                  w_rresp_nxt    = RESP_SLVERR;
                  w_data_hit_nxt = 1'b0;
               end
            end
         end
         ST_RESP: begin
            if (bus.rready) begin
               w_state_nxt    = ST_IDLE;
               w_rvalid_nxt   = 1'b0;
               w_adv          = r_data_hit;
               w_data_hit_nxt = 1'b0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Registered read-channel outputs
   always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
      if (!rst_main_n_sync) begin
         r_rvalid   <= 1'b0;
         r_rdata    <= 32'h0000_0000;
         r_rresp    <= 2'b00;
         r_data_hit <= 1'b0;
      end else begin
         r_rvalid   <= w_rvalid_nxt;
         r_rdata    <= w_rdata_nxt;
         r_rresp    <= w_rresp_nxt;
         r_data_hit <= w_data_hit_nxt;
      end
   end

   // Block storage; contents are don't-care until written
   always_ff @(posedge clk_main_a0) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.ct_data;
      end
   end

   // Pointers, occupancy and byte/word pointer
   always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
      if (!rst_main_n_sync) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_bp     <= 4'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (w_adv) begin
            r_bp <= (r_bp == BP_LAST) ? 4'd0 : r_bp + 4'd1;
         end
      end
   end

endmodule
